// File: rtl/spio_edvs_event_assembler_pkg.sv
// Shared definitions for the eDVS event assembler: FSM states, packet
// layout, key field offsets and the odd-parity helper.
package spio_edvs_event_assembler_pkg;

    localparam int PKT_W        = 72;
    localparam int KEY_W        = 32;
    localparam int COORD_W      = 7;
    localparam int PREFIX_W     = 16;

    // Packet field positions
    localparam int KEY_LSB      = 8;
    localparam int HDR_TYPE_LSB = 6;
    localparam int HDR_TYPE_W   = 2;
    localparam int HDR_PAR_BIT  = 0;

    // Key field offsets
    localparam int Y_LSB        = 8;
    localparam int X_LSB        = 1;
    localparam int POL_BIT      = 0;

    localparam logic [HDR_TYPE_W-1:0] HDR_TYPE_MC = 2'b00;

    typedef enum logic [0:0] {
        WAIT_Y = 1'b0,
        WAIT_X = 1'b1
    } edvs_state_e;

    // Parity bit value that makes a packet (with its parity bit at 0) odd overall.
    function automatic logic odd_parity_fill(input logic [PKT_W-1:0] pkt);
        return ~(^pkt);
    endfunction

endpackage

// File: rtl/spio_edvs_event_assembler_if.sv
// Byte-in / packet-out handshake bundle of the eDVS event assembler.
// slave  : the assembler (consumes bytes, produces packets)
// master : the environment (UART receiver side and FIFO side)
interface spio_edvs_event_assembler_if #(
    parameter int BYTE_W = 8,
    parameter int PKT_W  = 72
);
    logic [BYTE_W-1:0] RX_DATA_IN;
    logic              RX_VLD_IN;
    logic              RX_RDY_OUT;
    logic [PKT_W-1:0]  PKT_DATA_OUT;
    logic              PKT_VLD_OUT;
    logic              PKT_RDY_IN;

    modport slave (
        input  RX_DATA_IN,
        input  RX_VLD_IN,
        output RX_RDY_OUT,
        output PKT_DATA_OUT,
        output PKT_VLD_OUT,
        input  PKT_RDY_IN
    );

    modport master (
        output RX_DATA_IN,
        output RX_VLD_IN,
        input  RX_RDY_OUT,
        input  PKT_DATA_OUT,
        input  PKT_VLD_OUT,
        output PKT_RDY_IN
    );
endinterface

// File: rtl/spio_edvs_event_assembler_pkt_build.sv
// Combinational builder: {KEY_PREFIX, y, x, polarity} -> 72-bit multicast
// packet with zero payload and odd overall parity. Usable by any event source.
module spio_edvs_pkt_build
    import spio_edvs_event_assembler_pkg::*;
#(
    parameter logic [PREFIX_W-1:0] KEY_PREFIX = 16'h0000
) (
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic               pol_i,
    output logic [PKT_W-1:0]   pkt_o
);

    logic [KEY_W-1:0] key_s;
    logic [PKT_W-1:0] raw_s;

    // Assemble key and header, then fill in the parity bit over the whole packet.
    always_comb begin
        key_s                        = {KEY_W{1'b0}};
        key_s[KEY_W-1 -: PREFIX_W]   = KEY_PREFIX;
        key_s[Y_LSB +: COORD_W]      = y_i;
        key_s[X_LSB +: COORD_W]      = x_i;
        key_s[POL_BIT]               = pol_i;

        raw_s                             = {PKT_W{1'b0}};
        raw_s[KEY_LSB +: KEY_W]           = key_s;
        raw_s[HDR_TYPE_LSB +: HDR_TYPE_W] = HDR_TYPE_MC;

        pkt_o              = raw_s;
        pkt_o[HDR_PAR_BIT] = odd_parity_fill(raw_s);
    end

endmodule

// File: rtl/spio_edvs_event_assembler.sv
// eDVS E0 event assembler: pairs Y/X bytes from the UART receiver into
// SpiNNaker multicast packets held in a single output register.
// Optional build macro EDVS_DROP_ON_FULL_EN: never stall the byte stream;
// an event completing while the packet register is blocked is dropped and
// counted instead. Without it, the X byte is back-pressured.
module spio_edvs_event_assembler
    import spio_edvs_event_assembler_pkg::*;
#(
    parameter logic [PREFIX_W-1:0] KEY_PREFIX = 16'h0000,
    parameter int                  CNT_BITS   = 16
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    spio_edvs_event_assembler_if.slave    edvs,
    output logic [CNT_BITS-1:0]           SYNC_ERR_COUNT_OUT,
    output logic [CNT_BITS-1:0]           DROP_COUNT_OUT
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    edvs_state_e         state_q, state_d;
    logic [COORD_W-1:0]  y_q, y_d;
    logic [PKT_W-1:0]    pkt_q, pkt_d;
    logic                pkt_vld_q, pkt_vld_d;
    logic [CNT_BITS-1:0] sync_cnt_q, sync_cnt_d;
    logic [PKT_W-1:0]    pkt_built_s;
    logic                stall_s;
    logic                rx_rdy_s;
    logic                accept_s;
    logic                load_s;
    logic                sync_inc_s;
`ifdef EDVS_DROP_ON_FULL_EN
    logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
    logic                drop_inc_s;
`endif

    spio_edvs_pkt_build #(
        .KEY_PREFIX (KEY_PREFIX)
    ) u_pkt_build (
        .y_i   (y_q),
        .x_i   (edvs.RX_DATA_IN[COORD_W-1:0]),
        .pol_i (edvs.RX_DATA_IN[COORD_W]),
        .pkt_o (pkt_built_s)
    );

    // Packet register is occupied and the FIFO is not taking it this cycle.
    assign stall_s = pkt_vld_q && !edvs.PKT_RDY_IN;

`ifdef EDVS_DROP_ON_FULL_EN
    assign rx_rdy_s = !RESET_IN;
`else
    assign rx_rdy_s = !RESET_IN && !((state_q == WAIT_X) && stall_s);
`endif

    assign accept_s = edvs.RX_VLD_IN && rx_rdy_s;

    // FSM next state: hunt for a Y byte, then complete the event on any byte.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        load_s     = 1'b0;
        sync_inc_s = 1'b0;
`ifdef EDVS_DROP_ON_FULL_EN
        drop_inc_s = 1'b0;
`endif
        case (state_q)
            WAIT_Y: begin
                if (accept_s) begin
                    if (edvs.RX_DATA_IN[COORD_W]) begin
                        y_d     = edvs.RX_DATA_IN[COORD_W-1:0];
                        state_d = WAIT_X;
                    end else begin
                        sync_inc_s = 1'b1;
                    end
                end else begin
                    state_d = WAIT_Y;
                end
            end
            WAIT_X: begin
                if (accept_s) begin
                    state_d = WAIT_Y;
`ifdef EDVS_DROP_ON_FULL_EN
                    if (stall_s) begin
                        drop_inc_s = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
`else
                    load_s = 1'b1;
`endif
                end else begin
                    state_d = WAIT_X;
                end
            end
            default: begin
                state_d = WAIT_Y;
            end
        endcase
    end

    // Packet register: a load wins over a drain so back-to-back events see no bubble.
    always_comb begin
        pkt_d     = pkt_q;
        pkt_vld_d = pkt_vld_q;
        if (load_s) begin
            pkt_d     = pkt_built_s;
            pkt_vld_d = 1'b1;
        end else if (pkt_vld_q && edvs.PKT_RDY_IN) begin
            pkt_vld_d = 1'b0;
        end else begin
            pkt_vld_d = pkt_vld_q;
        end
    end

    // Saturating counters: stop at all-ones instead of wrapping.
    always_comb begin
        sync_cnt_d = sync_cnt_q;
        if (sync_inc_s && (sync_cnt_q != CNT_MAX)) begin
            sync_cnt_d = sync_cnt_q + CNT_ONE;
        end else begin
            sync_cnt_d = sync_cnt_q;
        end
`ifdef EDVS_DROP_ON_FULL_EN
        drop_cnt_d = drop_cnt_q;
        if (drop_inc_s && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
`endif
    end

    // State, packet and counter registers with synchronous reset.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state_q    <= WAIT_Y;
            y_q        <= {COORD_W{1'b0}};
            pkt_q      <= {PKT_W{1'b0}};
            pkt_vld_q  <= 1'b0;
            sync_cnt_q <= {CNT_BITS{1'b0}};
`ifdef EDVS_DROP_ON_FULL_EN
            drop_cnt_q <= {CNT_BITS{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            pkt_q      <= pkt_d;
            pkt_vld_q  <= pkt_vld_d;
            sync_cnt_q <= sync_cnt_d;
`ifdef EDVS_DROP_ON_FULL_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign edvs.RX_RDY_OUT   = rx_rdy_s;
    assign edvs.PKT_DATA_OUT = pkt_q;
    // A pending packet must not be offered while reset is being applied.
    assign edvs.PKT_VLD_OUT  = pkt_vld_q && !RESET_IN;
    assign SYNC_ERR_COUNT_OUT = sync_cnt_q;
`ifdef EDVS_DROP_ON_FULL_EN
    assign DROP_COUNT_OUT = drop_cnt_q;
`else
    assign DROP_COUNT_OUT = {CNT_BITS{1'b0}};
`endif

endmodule

// File: doc/spio_edvs_event_assembler.md
Name: spio_edvs_event_assembler

Overview:
Upstream stage of spio_uart_fifo. Consumes the eDVS camera byte stream from the UART receiver and assembles 2-byte eDVS events (E0 format). Each event becomes one 72-bit SpiNNaker multicast packet, presented on a rdy/vld output that feeds the FIFO input directly. Re-synchronises on corrupted framing and counts errors.

Parameters:
KEY_PREFIX, 16'h0000, upper 16 bits of every generated routing key.
CNT_BITS, 16, width of the saturating error/drop counters.

Ports:
CLK_IN  input  1  common clock; all logic on rising edge.
RESET_IN  input  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
RX_DATA_IN  input  8  byte from the UART receiver.
RX_VLD_IN  input  1  RX_DATA_IN valid.
RX_RDY_OUT  output  1  byte accepted when RX_VLD_IN && RX_RDY_OUT.
PKT_DATA_OUT  output  72  packet: [71:40] payload (zero), [39:8] key, [7:0] header.
PKT_VLD_OUT  output  1  packet register holds a packet.
PKT_RDY_IN  input  1  downstream (FIFO IN_RDY_OUT) ready.
SYNC_ERR_COUNT_OUT  output  CNT_BITS  saturating count of bytes discarded while hunting for the Y byte.
DROP_COUNT_OUT  output  CNT_BITS  saturating count of dropped events (see Optional Feature).

Behaviour:
- eDVS E0 event: byte0 = 1yyyyyyy (MSB marker), byte1 = pxxxxxxx (p = polarity).
- Key = {KEY_PREFIX, 1'b0, y[6:0], x[6:0], p}.
- Header: [7:6]=2'b00 (MC); [5:1]=0 (no payload); [0]=parity, chosen so all 72 bits have odd parity.
- FSM, 2 states:
  - WAIT_Y: accepted byte with MSB=1 -> latch y, go to WAIT_X. Accepted byte with MSB=0 -> discard, SYNC_ERR_COUNT_OUT+1, stay.
  - WAIT_X: any accepted byte completes the event -> load packet register, go to WAIT_Y.
- Packet register: PKT_VLD_OUT set on load, cleared on PKT_VLD_OUT && PKT_RDY_IN unless reloaded the same cycle.
  - Simultaneous drain and load: new packet replaces the old one, PKT_VLD_OUT stays 1. No bubble, so throughput is 1 packet per 2 bytes.
- Backpressure: RX_RDY_OUT = !(state==WAIT_X && PKT_VLD_OUT && !PKT_RDY_IN). Always 1 in WAIT_Y.
  - Combinational path PKT_RDY_IN -> RX_RDY_OUT is allowed; the FIFO's ready is register-driven, so no loop.
- Latency: packet visible on PKT_DATA_OUT the cycle after the X byte is accepted.
- PKT_DATA_OUT is held stable while PKT_VLD_OUT && !PKT_RDY_IN.
- Counters saturate at all-ones and never wrap.
- Reset: state=WAIT_Y, PKT_VLD_OUT=0, PKT_DATA_OUT=0, both counters=0, RX_RDY_OUT=1 after reset.
  - Reset mid-event discards the half-assembled y. Reset with a packet pending discards it.
- While RESET_IN is high, RX_RDY_OUT=0 and PKT_VLD_OUT=0.

Optional Feature:
Macro EDVS_DROP_ON_FULL_EN.
- Defined: RX_RDY_OUT=1 always (except during reset). An X byte arriving while PKT_VLD_OUT && !PKT_RDY_IN completes the event but does not load it; the event is discarded, DROP_COUNT_OUT+1, and the FSM returns to WAIT_Y.
- Not defined: backpressure as above, and DROP_COUNT_OUT tied to 0.

Decomposition:
- Shared header spio_edvs_common.h: FSM state encodings, header field positions/widths, key field offsets (Y_LSB=8, X_LSB=1, POL_BIT=0), packet width 72.
- Sub-module spio_edvs_pkt_build: combinational {KEY_PREFIX,y,x,p} -> 72-bit packet with parity. Instantiated once, and reusable by other event sources.

Test Plan:
- KEY_PREFIX=16'h1234, bytes 0x85, 0x23, PKT_RDY_IN=1 -> one cycle later PKT_DATA_OUT={32'h0, 32'h12340546, 8'h01}, PKT_VLD_OUT=1 for exactly 1 cycle.
- Bytes 0x05, 0x7F, 0x85, 0x23 -> SYNC_ERR_COUNT_OUT=2, single packet identical to the first scenario.
- PKT_RDY_IN=0, send 0x81,0x02 then 0x83 -> 0x83 accepted. The next byte stalls with RX_RDY_OUT=0 until PKT_RDY_IN=1; first packet held stable; second packet emitted after drain.
- With EDVS_DROP_ON_FULL_EN, PKT_RDY_IN=0, two full events -> first held, second dropped, DROP_COUNT_OUT=1, RX_RDY_OUT never low.
- Assert RESET_IN after byte 0x85 only, then send 0x23,0x85,0x23 -> first 0x23 counted as sync error (count=1), one packet out.
- CNT_BITS=4, 20 bytes with MSB=0 -> SYNC_ERR_COUNT_OUT saturates at 4'hF.
